// File: rtl/ram_dual_pkg.sv
// Shared definitions for the ram_dual 64 x 8 RAM and its read-side burst master.
package ram_dual_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 6;

   typedef logic [DEF_DATA_WIDTH-1:0] data_t;
   typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

endpackage

// File: rtl/ram_burst_reader_skid_fifo2.sv
// Two-entry FIFO that absorbs RAM read returns while the stream consumer stalls.
module skid_fifo2
   import ram_dual_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read master for ram_dual: issues sequential read addresses and streams
// the returned words out through a 2-entry skid FIFO on a valid/ready port.
module ram_burst_reader
   import ram_dual_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [DATA_WIDTH-1:0] q,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   state_t                state;
   state_t                state_nx;
   logic [ADDR_WIDTH-1:0] addr_nx;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  len_nx;
   logic [LEN_WIDTH-1:0]  issued;
   logic [LEN_WIDTH-1:0]  issued_nx;
   logic [LEN_WIDTH-1:0]  accepted;
   logic [LEN_WIDTH-1:0]  accepted_nx;
   logic                  inflight;
   logic                  issue;
   logic                  done_nx;
   logic                  handshake;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [1:0]            fifo_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         read_addr <= '0;
         len_q     <= '0;
         issued    <= '0;
         accepted  <= '0;
         inflight  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         read_addr <= addr_nx;
         len_q     <= len_nx;
         issued    <= issued_nx;
         accepted  <= accepted_nx;
         inflight  <= issue;
         done      <= done_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      addr_nx     = read_addr;
      len_nx      = len_q;
      issued_nx   = issued;
      accepted_nx = accepted;
      issue       = 1'b0;
      done_nx     = 1'b0;
      handshake   = out_valid & out_ready;

      case (state)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  state_nx    = RUN;
                  addr_nx     = base_addr;
                  len_nx      = length;
                  issued_nx   = '0;
                  accepted_nx = '0;
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         RUN: begin
            // The pop happening this cycle frees its slot, so a read may issue into it
            // and sustain one word per cycle; FIFO + in-flight never exceeds 2 after the edge.
            if (issued < len_q) begin
               if (fifo_full) begin
                  issue = handshake;
               end else begin
                  issue = (3'(inflight) + 3'(fifo_count)) < (3'd2 + 3'(handshake));
               end
            end
            if (issue) begin
               addr_nx   = read_addr + ADDR_WIDTH'(1);
               issued_nx = issued + LEN_WIDTH'(1);
            end
            if (handshake) begin
               accepted_nx = accepted + LEN_WIDTH'(1);
               if (accepted_nx == len_q) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end
            end
         end
      endcase
   end

   skid_fifo2 #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (inflight),
      .push_data(q),
      .pop      (handshake),
      .head     (out_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign out_valid = ~fifo_empty;
   assign busy      = (state == RUN);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a registered-read RAM model and a data scoreboard.
module tb_ram_burst_reader;
   import ram_dual_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   addr_t       base_addr;
   logic [6:0]  length;
   logic        busy;
   logic        done;
   addr_t       read_addr;
   data_t       q;
   data_t       out_data;
   logic        out_valid;
   logic        out_ready;

   data_t       mem [64];
   data_t       exp_q [$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          beats = 0;
   int          done_count = 0;
   logic        prev_stall = 1'b0;
   logic        prev2_stall = 1'b0;
   data_t       prev_data;
   addr_t       prev_addr;

   always #5 clock = ~clock;

   // RAM read port: address sampled at the edge, data valid the following cycle.
   always @(posedge clock) q <= mem[read_addr];

   ram_burst_reader dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .base_addr(base_addr),
      .length   (length),
      .busy     (busy),
      .done     (done),
      .read_addr(read_addr),
      .q        (q),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      logic  stall;
      data_t e;
      if (done) done_count++;
      if (prev_stall) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, prev_data);
      end
      if (prev2_stall && prev_stall) check("addr_stall", read_addr, prev_addr);
      if (out_valid && out_ready) begin
         check("beat_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e);
         end
         beats++;
      end
      stall       = out_valid && !out_ready;
      prev2_stall = prev_stall;
      prev_stall  = stall;
      prev_data   = out_data;
      prev_addr   = read_addr;
   end

   task automatic start_burst(input addr_t b, input logic [6:0] n);
      @(posedge clock);
      #1;
      start     = 1'b1;
      base_addr = b;
      length    = n;
      for (int i = 0; i < int'(n); i++) exp_q.push_back(data_t'(((int'(b) + i) % 64) + 'h40));
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!done && k < 200) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_drained"}, exp_q.size(), 0);
      @(negedge clock);
      check({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    k;
      int    b0;
      int    dc0;
      addr_t addr_tab [4];
      logic  pat [6];

      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = data_t'(i + 'h40);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr", read_addr, 0);
      check("rst_valid", out_valid, 0);

      // basic burst, full throughput
      start_burst(6'd3, 7'd4);
      @(negedge clock);
      check("t1_busy", busy, 1);
      check("t1_addr0", read_addr, 3);
      check("t1_valid_c1", out_valid, 0);
      @(negedge clock);
      check("t1_valid_c2", out_valid, 0);
      check("t1_addr1", read_addr, 4);
      @(negedge clock);
      check("t1_valid_c3", out_valid, 1);
      check("t1_first", out_data, 8'h43);
      k = 3;
      while (!done && k < 20) begin
         @(negedge clock);
         k++;
      end
      check("t1_done_cycle", k, 7);
      check("t1_busy_end", busy, 0);
      wait_done("t1");

      // address wrap 62,63,0,1
      addr_tab = '{6'd62, 6'd63, 6'd0, 6'd1};
      start_burst(6'd62, 7'd4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("t2_addr", read_addr, addr_tab[i]);
      end
      wait_done("t2");

      // backpressure with a toggling ready
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      start_burst(6'd20, 7'd8);
      for (int c = 0; c < 100; c++) begin
         out_ready = pat[c % 6];
         @(negedge clock);
         if (done) break;
         @(posedge clock);
         #1;
      end
      out_ready = 1'b1;
      wait_done("t3");

      // zero-length command
      start_burst(6'd7, 7'd0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clock);
         check("t4_done", done, (i == 1) ? 1 : 0);
         check("t4_busy", busy, 0);
         check("t4_valid", out_valid, 0);
      end

      // reset mid-burst
      b0 = beats;
      start_burst(6'd0, 7'd6);
      k = 0;
      while (beats < b0 + 2 && k < 20) begin
         @(posedge clock);
         k++;
      end
      check("t5_two_beats", beats >= b0 + 2, 1);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      exp_q.delete();
      @(negedge clock);
      check("t5_busy", busy, 0);
      check("t5_valid", out_valid, 0);
      check("t5_addr", read_addr, 0);
      for (int i = 0; i < 4; i++) begin
         check("t5_no_done", done, 0);
         @(negedge clock);
      end
      start_burst(6'd0, 7'd2);
      wait_done("t5b");

      // start while busy is ignored
      start_burst(6'd5, 7'd6);
      @(posedge clock);
      #1;
      start     = 1'b1;
      base_addr = 6'd20;
      length    = 7'd3;
      @(posedge clock);
      #1 start = 1'b0;
      wait_done("t6");
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("t6_idle_valid", out_valid, 0);
         check("t6_idle_busy", busy, 0);
      end

      // full-depth bursts, single done pulse
      dc0 = done_count;
      start_burst(6'd0, 7'd64);
      wait_done("t7");
      @(posedge clock);
      check("t7_one_done", done_count - dc0, 1);
      start_burst(6'd10, 7'd64);
      wait_done("t8");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
